dpram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that drives the write and read ports of the 8-bit dpram macro wrapper.
//  It generates waddr/wdata/we and raddr, and captures rdata.
//  It presents a push/pop FIFO interface to datapath logic, with occupancy count, almost-full
//  and sticky error flags. Sits between stream producers/consumers and one dpram instance.

---
 rtl/dpram_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// Push/pop FIFO controller that drives one dual-port RAM: the write port is used on push, and the read port
// is sampled on pop. Status flags are decoded from the registered wrap-bit pointers.
module dpram_fifo_ctrl #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int AF_LEVEL = 240
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full_c, empty_c, push_ok, pop_ok;
    logic [AW:0]   count_c;

    // Full and empty share the same low address bits and differ only in the wrap bit.
    always_comb begin
        full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_c = (wr_ptr_q == rd_ptr_q);
        count_c = wr_ptr_q - rd_ptr_q;
        push_ok = wr_en && !full_c;
        pop_ok  = rd_en && !empty_c;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (wr_en) begin
            overflow_d = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = ram_rdata;
            rd_valid_d = 1'b1;
        end else if (rd_en) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign full        = full_c;
    assign empty       = empty_c;
    assign count       = count_c;
    assign almost_full = (count_c >= AF_LVL);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign ram_waddr   = wr_ptr_q[AW-1:0];
    assign ram_wdata   = wr_data;
    assign ram_we      = push_ok;
    assign ram_raddr   = rd_ptr_q[AW-1:0];

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM attached.
// It uses a directed vector table followed by hand-written fill, wrap, underflow and reset sequences.
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, overflow, underflow;
    logic [8:0] count;
    logic [7:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;
    logic       ram_we;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // Behavioural dpram: synchronous write, read data valid for raddr before the next edge.
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = mem[ram_raddr];

    dpram_fifo_ctrl #(.AW(8), .DW(8), .AF_LEVEL(240)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       rd_en;
        logic       exp_we;
        logic [7:0] exp_waddr;
        logic [8:0] exp_count;
        logic       exp_empty;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic       exp_uflow;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Watchdog so a broken design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_byte;

        vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b1, 8'd0, 9'd1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'd1, 9'd2, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'd2, 9'd3, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 9'd2, 1'b0, 1'b1, 8'h55, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 9'd1, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 9'd0, 1'b1, 1'b1, 8'h5A, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 9'd0, 1'b1, 1'b0, 8'h5A, 1'b0};
        vecs[7] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'd3, 9'd1, 1'b0, 1'b0, 8'h5A, 1'b1};
        vecs[8] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'd4, 9'd1, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd5, 9'd0, 1'b1, 1'b1, 8'h22, 1'b1};

        // Reset state.
        doReset();
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_underflow", 32'(underflow), 32'd0);
        checkOutput("reset_almost_full", 32'(almost_full), 32'd0);

        // Directed push/pop vectors, including simultaneous push and pop from the empty state.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
            checkOutput($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_ram_waddr", i), 32'(ram_waddr), 32'(vecs[i].exp_waddr));
            tick();
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            checkOutput($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
            checkOutput($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uflow));
        end

        // Fill to full, watching the almost-full and full thresholds.
        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            if (i == 255) checkOutput("fill_last_waddr", 32'(ram_waddr), 32'd255);
            tick();
            if (i == 238) checkOutput("af_at_239", 32'(almost_full), 32'd0);
            if (i == 239) checkOutput("af_at_240", 32'(almost_full), 32'd1);
            if (i == 254) checkOutput("full_at_255", 32'(full), 32'd0);
        end
        checkOutput("full_at_256", 32'(full), 32'd1);
        checkOutput("count_256", 32'(count), 32'd256);
        checkOutput("af_at_256", 32'(almost_full), 32'd1);

        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("push257_ram_we", 32'(ram_we), 32'd0);
        tick();
        checkOutput("push257_overflow", 32'(overflow), 32'd1);
        checkOutput("push257_count", 32'(count), 32'd256);

        // Push and pop together while full: the pop wins and the push is dropped.
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("fullpp_ram_we", 32'(ram_we), 32'd0);
        tick();
        checkOutput("fullpp_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("fullpp_rd_data", 32'(rd_data), 32'h00);
        checkOutput("fullpp_count", 32'(count), 32'd255);
        checkOutput("fullpp_raddr", 32'(ram_raddr), 32'd1);
        checkOutput("fullpp_waddr", 32'(ram_waddr), 32'd0);
        checkOutput("fullpp_full", 32'(full), 32'd0);

        // Drain the rest; the data shows the rejected pushes never landed.
        for (int i = 1; i < 256; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            tick();
            checkOutput($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
        end
        checkOutput("drained_empty", 32'(empty), 32'd1);

        // Steady push+pop across many address wraps, checked against a reference queue.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'(8'hA0 + k), 1'b0);
            q.push_back(8'(8'hA0 + k));
            tick();
        end
        checkOutput("stream_prefill_count", 32'(count), 32'd5);
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'b1, 8'(c * 7 + 3), 1'b1);
            exp_byte = q.pop_front();
            q.push_back(8'(c * 7 + 3));
            tick();
            checkOutput($sformatf("stream%0d_count", c), 32'(count), 32'd5);
            checkOutput($sformatf("stream%0d_rv", c), 32'(rd_valid), 32'd1);
            checkOutput($sformatf("stream%0d_data", c), 32'(rd_data), 32'(exp_byte));
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            exp_byte = q.pop_front();
            tick();
            checkOutput($sformatf("tail%0d_data", k), 32'(rd_data), 32'(exp_byte));
        end

        // Pop while empty, then reset in the middle of traffic.
        checkOutput("pre_uflow", 32'(underflow), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("uflow_set", 32'(underflow), 32'd1);
        checkOutput("uflow_rv", 32'(rd_valid), 32'd0);
        checkOutput("uflow_overflow_sticky", 32'(overflow), 32'd1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
            tick();
        end
        checkOutput("midrst_count10", 32'(count), 32'd10);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("midrst_rv_before", 32'(rd_valid), 32'd1);
        applyStimulus(1'b1, 8'h99, 1'b0);
        tick();
        checkOutput("midrst_count10b", 32'(count), 32'd10);
        rstn = 1'b0;
        applyStimulus(1'b1, 8'h99, 1'b1);
        tick();
        rstn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        checkOutput("midrst_rv", 32'(rd_valid), 32'd0);
        checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_underflow", 32'(underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
